// File: rtl/detect_sched_if.sv
// Descriptor bus between the detect-head sequencer (master) and the
// convolution engine and run controller (slave).
interface detect_sched_if;
  // A descriptor transfers on a rising edge where job_valid && job_ready.
  // While job_valid is high and not yet accepted, every job_* field holds steady.
  // job_valid never waits for job_ready before it rises.
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic        job_valid;
  logic        job_ready;
  logic [1:0]  job_scale;
  logic        job_branch;
  logic [1:0]  job_layer;
  logic [15:0] job_in_ch;
  logic [15:0] job_out_ch;
  logic [15:0] job_h;
  logic [15:0] job_w;
  logic [1:0]  job_k;
  logic        job_pad;
  logic        job_bn_act;
  logic [1:0]  job_src;
  logic [1:0]  job_dst;
  logic [31:0] job_out_base;
  logic        eng_done;
  logic [4:0]  job_idx;

  modport master (
    input  start, abort, job_ready, eng_done,
    output busy, done, job_valid, job_scale, job_branch, job_layer,
           job_in_ch, job_out_ch, job_h, job_w, job_k, job_pad, job_bn_act,
           job_src, job_dst, job_out_base, job_idx
  );

  modport slave (
    output start, abort, job_ready, eng_done,
    input  busy, done, job_valid, job_scale, job_branch, job_layer,
           job_in_ch, job_out_ch, job_h, job_w, job_k, job_pad, job_bn_act,
           job_src, job_dst, job_out_base, job_idx
  );
endinterface

// File: rtl/detect_sched.sv
// Walks the 18 YOLO detect-head jobs (scale, branch, layer) on one shared
// convolution engine, issuing one descriptor per job and waiting for completion.
module detect_sched #(
  parameter int IN_CH1 = 1,
  parameter int IN_CH2 = 1,
  parameter int IN_CH3 = 1,
  parameter int IN_H1  = 1,
  parameter int IN_W1  = 1,
  parameter int IN_H2  = 1,
  parameter int IN_W2  = 1,
  parameter int IN_H3  = 1,
  parameter int IN_W3  = 1,
  parameter int REG_CH = 64,
  parameter int CLS_CH = 80
) (
  input  logic              clk,
  input  logic              rst,
  detect_sched_if.master    bus,
  output logic [1:0]        state_o
);
  localparam int OUT_CH = REG_CH + CLS_CH;
  localparam int HW1 = IN_H1 * IN_W1;
  localparam int HW2 = IN_H2 * IN_W2;
  localparam int HW3 = IN_H3 * IN_W3;
  localparam logic [31:0] BASE_R1 = 32'd0;
  localparam logic [31:0] BASE_C1 = 32'(REG_CH * HW1);
  localparam logic [31:0] BASE_R2 = 32'(OUT_CH * HW1);
  localparam logic [31:0] BASE_C2 = 32'(OUT_CH * HW1 + REG_CH * HW2);
  localparam logic [31:0] BASE_R3 = 32'(OUT_CH * (HW1 + HW2));
  localparam logic [31:0] BASE_C3 = 32'(OUT_CH * (HW1 + HW2) + REG_CH * HW3);
  localparam logic [4:0]  LAST_JOB = 5'd17;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [1:0]  scale_q, scale_d;
  logic        branch_q, branch_d;
  logic [1:0]  layer_q, layer_d;
  logic        done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= 5'd0;
      scale_q  <= 2'd0;
      branch_q <= 1'b0;
      layer_q  <= 2'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      scale_q  <= scale_d;
      branch_q <= branch_d;
      layer_q  <= layer_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    scale_d  = scale_q;
    branch_d = branch_q;
    layer_d  = layer_q;
    done_d   = 1'b0;
    if (bus.abort) begin
      state_d  = IDLE;
      idx_d    = 5'd0;
      scale_d  = 2'd0;
      branch_d = 1'b0;
      layer_d  = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d  = ISSUE;
            idx_d    = 5'd0;
            scale_d  = 2'd0;
            branch_d = 1'b0;
            layer_d  = 2'd0;
          end
        end
        ISSUE: begin
          if (bus.job_ready) state_d = WAIT;
        end
        WAIT: begin
          if (bus.eng_done) begin
            if (idx_q == LAST_JOB) begin
              state_d  = IDLE;
              done_d   = 1'b1;
              idx_d    = 5'd0;
              scale_d  = 2'd0;
              branch_d = 1'b0;
              layer_d  = 2'd0;
            end else begin
              state_d = ISSUE;
              idx_d   = idx_q + 5'd1;
              // Layer is innermost, then branch, then scale.
              if (layer_q == 2'd2) begin
                layer_d = 2'd0;
                if (branch_q) begin
                  branch_d = 1'b0;
                  scale_d  = scale_q + 2'd1;
                end else begin
                  branch_d = 1'b1;
                end
              end else begin
                layer_d = layer_q + 2'd1;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  logic [15:0] chan, sc_in_ch, sc_h, sc_w;
  logic [31:0] sc_base;

  always_comb begin
    chan = branch_q ? 16'(CLS_CH) : 16'(REG_CH);
    case (scale_q)
      2'd1: begin
        sc_in_ch = 16'(IN_CH2);
        sc_h     = 16'(IN_H2);
        sc_w     = 16'(IN_W2);
        sc_base  = branch_q ? BASE_C2 : BASE_R2;
      end
      2'd2: begin
        sc_in_ch = 16'(IN_CH3);
        sc_h     = 16'(IN_H3);
        sc_w     = 16'(IN_W3);
        sc_base  = branch_q ? BASE_C3 : BASE_R3;
      end
      default: begin
        sc_in_ch = 16'(IN_CH1);
        sc_h     = 16'(IN_H1);
        sc_w     = 16'(IN_W1);
        sc_base  = branch_q ? BASE_C1 : BASE_R1;
      end
    endcase
  end

  // Geometry fields read zero while idle so every output is 0 out of reset.
  always_comb begin
    bus.job_in_ch    = 16'd0;
    bus.job_out_ch   = 16'd0;
    bus.job_h        = 16'd0;
    bus.job_w        = 16'd0;
    bus.job_k        = 2'd0;
    bus.job_pad      = 1'b0;
    bus.job_bn_act   = 1'b0;
    bus.job_src      = 2'd0;
    bus.job_dst      = 2'd0;
    bus.job_out_base = 32'd0;
    if (state_q != IDLE) begin
      bus.job_out_ch = chan;
      bus.job_h      = sc_h;
      bus.job_w      = sc_w;
      case (layer_q)
        2'd0: begin
          bus.job_in_ch  = sc_in_ch;
          bus.job_k      = 2'd3;
          bus.job_pad    = 1'b1;
          bus.job_bn_act = 1'b1;
          bus.job_src    = 2'd0;
          bus.job_dst    = 2'd1;
        end
        2'd1: begin
          bus.job_in_ch  = chan;
          bus.job_k      = 2'd3;
          bus.job_pad    = 1'b1;
          bus.job_bn_act = 1'b1;
          bus.job_src    = 2'd1;
          bus.job_dst    = 2'd2;
        end
        default: begin
          bus.job_in_ch    = chan;
          bus.job_k        = 2'd1;
          bus.job_src      = 2'd2;
          bus.job_dst      = 2'd3;
          bus.job_out_base = sc_base;
        end
      endcase
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.job_valid  = (state_q == ISSUE);
  assign bus.job_idx    = idx_q;
  assign bus.job_scale  = scale_q;
  assign bus.job_branch = branch_q;
  assign bus.job_layer  = layer_q;
  assign state_o        = state_q;
endmodule

// File: tb/tb_detect_sched.sv
// Bench for detect_sched: small head (REG_CH=4, CLS_CH=3, scale 1 at 2x2,
// scales 2 and 3 at 1x1) driven through full, back-pressured, aborted and reset passes.
module tb_detect_sched;
  localparam int P_REG = 4;
  localparam int P_CLS = 3;

  logic       clk;
  logic       rst;
  logic [1:0] state_o;
  int         n_chk;
  int         n_fail;
  int         done_cnt;

  detect_sched_if bus ();

  detect_sched #(
    .IN_CH1(5), .IN_CH2(6), .IN_CH3(7),
    .IN_H1(2), .IN_W1(2), .IN_H2(1), .IN_W2(1), .IN_H3(1), .IN_W3(1),
    .REG_CH(P_REG), .CLS_CH(P_CLS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .state_o(state_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  // Reference model, computed directly from the job ordering rules.
  typedef struct {
    int scale, branch, layer, in_ch, out_ch, h, w, k, pad, bn, src, dst;
    int base;
  } desc_t;

  function automatic desc_t model(input int j);
    desc_t d;
    int in_tab[3];
    int h_tab[3];
    int w_tab[3];
    int chans;
    in_tab = '{5, 6, 7};
    h_tab  = '{2, 1, 1};
    w_tab  = '{2, 1, 1};
    d.scale  = j / 6;
    d.branch = (j / 3) % 2;
    d.layer  = j % 3;
    chans    = d.branch ? P_CLS : P_REG;
    d.in_ch  = (d.layer == 0) ? in_tab[d.scale] : chans;
    d.out_ch = chans;
    d.h      = h_tab[d.scale];
    d.w      = w_tab[d.scale];
    d.k      = (d.layer == 2) ? 1 : 3;
    d.pad    = (d.layer == 2) ? 0 : 1;
    d.bn     = (d.layer == 2) ? 0 : 1;
    d.src    = d.layer;
    d.dst    = d.layer + 1;
    d.base   = 0;
    if (d.layer == 2) begin
      for (int i = 0; i < d.scale; i++) d.base += (P_REG + P_CLS) * h_tab[i] * w_tab[i];
      if (d.branch == 1) d.base += P_REG * h_tab[d.scale] * w_tab[d.scale];
    end
    return d;
  endfunction

  // Hand-written vectors for selected jobs of the first pass.
  typedef struct {
    int          job;
    logic [31:0] base;
    logic [15:0] in_ch;
    logic [15:0] out_ch;
    logic [1:0]  k;
    logic [1:0]  dst;
  } vec_t;

  typedef struct {
    logic [31:0] base;
    logic [15:0] in_ch;
    logic [15:0] out_ch;
    logic [1:0]  k;
    logic [1:0]  dst;
  } cap_t;

  vec_t tbl[8];
  cap_t cap[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_desc(input int j);
    desc_t m;
    m = model(j);
    chk("job_idx", 32'(bus.job_idx), j);
    chk("job_scale", 32'(bus.job_scale), m.scale);
    chk("job_branch", 32'(bus.job_branch), m.branch);
    chk("job_layer", 32'(bus.job_layer), m.layer);
    chk("job_in_ch", 32'(bus.job_in_ch), m.in_ch);
    chk("job_out_ch", 32'(bus.job_out_ch), m.out_ch);
    chk("job_h", 32'(bus.job_h), m.h);
    chk("job_w", 32'(bus.job_w), m.w);
    chk("job_k", 32'(bus.job_k), m.k);
    chk("job_pad", 32'(bus.job_pad), m.pad);
    chk("job_bn_act", 32'(bus.job_bn_act), m.bn);
    chk("job_src", 32'(bus.job_src), m.src);
    chk("job_dst", 32'(bus.job_dst), m.dst);
    chk("job_out_base", bus.job_out_base, m.base);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_valid"}, 32'(bus.job_valid), 0);
    chk({tag, "_idx"}, 32'(bus.job_idx), 0);
    chk({tag, "_scale"}, 32'(bus.job_scale), 0);
    chk({tag, "_layer"}, 32'(bus.job_layer), 0);
    chk({tag, "_in_ch"}, 32'(bus.job_in_ch), 0);
    chk({tag, "_k"}, 32'(bus.job_k), 0);
    chk({tag, "_dst"}, 32'(bus.job_dst), 0);
    chk({tag, "_base"}, bus.job_out_base, 0);
    chk({tag, "_state"}, 32'(state_o), 0);
  endtask

  // Driver tasks; inputs change and outputs are sampled on the falling edge.
  task automatic start_pass();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("start_busy", 32'(bus.busy), 1);
    chk("start_valid", 32'(bus.job_valid), 1);
    chk("start_idx", 32'(bus.job_idx), 0);
  endtask

  // stop: 0 = finish normally, 1 = abort (with eng_done) while waiting, 2 = async reset while waiting
  task automatic run_job(input int j, input int rdly, input int ddly,
                         input bit start_w_done, input bit spur, input int stop);
    int budget;
    budget = 0;
    while (bus.job_valid !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    chk("valid_wait", 32'(bus.job_valid), 1);
    check_desc(j);
    cap[j].base   = bus.job_out_base;
    cap[j].in_ch  = bus.job_in_ch;
    cap[j].out_ch = bus.job_out_ch;
    cap[j].k      = bus.job_k;
    cap[j].dst    = bus.job_dst;
    for (int k = 0; k < rdly; k++) begin
      bus.job_ready = 1'b0;
      bus.eng_done  = spur && (k == 1);
      @(negedge clk);
      bus.eng_done = 1'b0;
      chk("hold_valid", 32'(bus.job_valid), 1);
      check_desc(j);
    end
    bus.job_ready = 1'b1;
    @(negedge clk);
    bus.job_ready = 1'b0;
    chk("acc_valid_low", 32'(bus.job_valid), 0);
    chk("acc_busy", 32'(bus.busy), 1);
    chk("acc_idx", 32'(bus.job_idx), j);
    for (int k = 1; k < ddly; k++) begin
      @(negedge clk);
      chk("wait_valid_low", 32'(bus.job_valid), 0);
    end
    if (stop == 1) begin
      bus.abort    = 1'b1;
      bus.eng_done = 1'b1;
      @(negedge clk);
      bus.abort    = 1'b0;
      bus.eng_done = 1'b0;
      check_zero("abort");
    end else if (stop == 2) begin
      #2 rst = 1'b1;
      #1 check_zero("async_rst");
      #1 rst = 1'b0;
      @(negedge clk);
      check_zero("post_rst");
    end else begin
      bus.eng_done = 1'b1;
      bus.start    = start_w_done;
      @(negedge clk);
      bus.eng_done = 1'b0;
      bus.start    = 1'b0;
      if (j < 17) begin
        chk("next_valid", 32'(bus.job_valid), 1);
        chk("next_idx", 32'(bus.job_idx), j + 1);
        chk("next_busy", 32'(bus.busy), 1);
        chk("next_done", 32'(bus.done), 0);
      end else begin
        chk("final_done", 32'(bus.done), 1);
        chk("final_busy", 32'(bus.busy), 0);
        chk("final_valid", 32'(bus.job_valid), 0);
      end
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    done_cnt = 0;
    tbl[0] = '{2,  32'd0,  16'd4, 16'd4, 2'd1, 2'd3};
    tbl[1] = '{5,  32'd16, 16'd3, 16'd3, 2'd1, 2'd3};
    tbl[2] = '{8,  32'd28, 16'd4, 16'd4, 2'd1, 2'd3};
    tbl[3] = '{11, 32'd32, 16'd3, 16'd3, 2'd1, 2'd3};
    tbl[4] = '{14, 32'd35, 16'd4, 16'd4, 2'd1, 2'd3};
    tbl[5] = '{17, 32'd39, 16'd3, 16'd3, 2'd1, 2'd3};
    tbl[6] = '{0,  32'd0,  16'd5, 16'd4, 2'd3, 2'd1};
    tbl[7] = '{12, 32'd0,  16'd7, 16'd4, 2'd3, 2'd1};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.job_ready = 1'b0;
    bus.eng_done = 1'b0;
    #3 check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero("idle");

    // Spurious completion while idle.
    bus.eng_done = 1'b1;
    @(negedge clk);
    bus.eng_done = 1'b0;
    check_zero("spur_idle");

    // Pass 1: ready at once, done 3 cycles after accept; stray starts ignored.
    start_pass();
    for (int j = 0; j < 18; j++) run_job(j, 0, 3, (j == 7) || (j == 17), 1'b0, 0);
    @(negedge clk);
    chk("p1_done_one_cycle", 32'(bus.done), 0);
    chk("p1_no_restart", 32'(bus.busy), 0);
    chk("p1_done_count", 32'(done_cnt), 1);
    for (int i = 0; i < 8; i++) begin
      chk("tbl_base", cap[tbl[i].job].base, tbl[i].base);
      chk("tbl_in_ch", 32'(cap[tbl[i].job].in_ch), 32'(tbl[i].in_ch));
      chk("tbl_out_ch", 32'(cap[tbl[i].job].out_ch), 32'(tbl[i].out_ch));
      chk("tbl_k", 32'(cap[tbl[i].job].k), 32'(tbl[i].k));
      chk("tbl_dst", 32'(cap[tbl[i].job].dst), 32'(tbl[i].dst));
    end

    // Pass 2: back-pressure and a spurious eng_done on job 4, abort on job 9.
    start_pass();
    for (int j = 0; j < 10; j++)
      run_job(j, (j == 4) ? 5 : int'($urandom_range(0, 2)), int'($urandom_range(1, 4)),
              1'b0, j == 4, (j == 9) ? 1 : 0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 1);
    chk("abort_idle", 32'(state_o), 0);

    // Pass 3: restart at job 0, asynchronous reset while waiting on job 12.
    start_pass();
    for (int j = 0; j < 13; j++)
      run_job(j, int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), 1'b0, 1'b0,
              (j == 12) ? 2 : 0);
    repeat (2) @(negedge clk);
    chk("rst_no_done", 32'(done_cnt), 1);

    // Pass 4: random timing to completion, then start during the done cycle.
    start_pass();
    for (int j = 0; j < 18; j++)
      run_job(j, int'($urandom_range(0, 3)), int'($urandom_range(1, 5)), 1'b0, 1'b0, 0);
    start_pass();
    chk("p4_done_count", 32'(done_cnt), 2);
    chk("p4_done_cleared", 32'(bus.done), 0);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_zero("final_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
